atconv_host: RTL and testbench
==============================

// Module: atconv_host
// PURPOSE
// - Host/memory-side end of the ATCONV accelerator interface.
// - Loads a 64x64 13-bit image from an input stream into image RAM, then raises `ready` to start the accelerator.
// - Serves `iaddr`/`idata` image reads and `cwr`/`crd`/`csel` layer-0/layer-1 memory accesses.
// - After `busy` falls, streams layer-1 results out.
// PARAMETERS
// DW          13      data width (image and layer memories)
// AW          12      address width
// IMG_DEPTH   4096    image RAM words (64x64)
// L0_DEPTH    4096    layer-0 RAM words (csel=0)
// L1_DEPTH    1024    layer-1 RAM words (csel=1)
// HS_TIMEOUT  16      max cycles `ready` may be held without `busy` rising
// RUN_TIMEOUT 1048575 max cycles `busy` may stay high
// PORTS
// clk        in   1   clock, all state on rising edge
// reset      in   1   synchronous active-low reset (0 = reset)
// in_valid   in   1   image stream word valid
// in_data    in   DW  image pixel, raster order
// in_ready   out  1   image stream accept
// ready      out  1   start request to accelerator
// busy       in   1   accelerator busy
// iaddr      in   AW  image read address
// idata      out  DW  image read data (signed)
// cwr        in   1   layer memory write enable
// caddr_wr   in   AW  layer write address
// cdata_wr   in   DW  layer write data
// crd        in   1   layer memory read enable
// caddr_rd   in   AW  layer read address
// cdata_rd   out  DW  layer read data
// csel       in   1   layer select: 0=L0, 1=L1
// out_valid  out  1   result stream valid
// out_data   out  DW  layer-1 word
// out_last   out  1   high with final word (index L1_DEPTH-1)
// out_ready  in   1   result stream accept
// done       out  1   1-cycle pulse when drain completes
// err        out  1   sticky timeout flag; cleared by reset or by the next load start
// BEHAVIOUR
// - Reset (reset==0 at edge):
//   - State IDLE; all counters = 0.
//   - Outputs in_ready/ready/out_valid/out_last/done/err = 0.
//   - RAM contents are not cleared.
// - States:
//   - IDLE: in_ready=1. First accepted word (in_valid&in_ready) is written to img[0], clears err, moves to LOAD.
//   - LOAD: in_ready=1. Each accepted word goes to img[wptr], wptr++. After word IMG_DEPTH-1 is accepted, go to HS.
//   - HS: ready=1, tmo counts.
//     - busy==1 sampled: ready=0 next cycle, go RUN.
//     - tmo==HS_TIMEOUT: err=1, go IDLE.
//   - RUN: wait for busy==0 sampled after busy was high, then go DRAIN with rptr=0.
//     - tmo > RUN_TIMEOUT: err=1, go IDLE.
//   - DRAIN: out_valid=1, out_data=L1[rptr], out_last=(rptr==L1_DEPTH-1).
//     - On out_valid&out_ready: rptr++.
//     - After the last word is accepted: done=1 for one cycle, go IDLE.
//     - out_data/out_last hold stable while out_valid&!out_ready.
// - Memory interface (all states, independent of FSM):
//   - idata = img[iaddr], combinational, zero latency.
//   - cdata_rd = crd ? (csel ? L1[caddr_rd[9:0]] : L0[caddr_rd]) : 0, combinational.
//   - On an edge with cwr=1: csel=0 writes L0[caddr_wr]; csel=1 writes L1[caddr_wr[9:0]]. Upper address bits are ignored for L1.
//   - cwr and crd on the same address in the same cycle: read returns the old value; the write lands at the edge.
//   - cwr and crd are honoured outside RUN as well (debug access).
// - Timeout counter tmo: clears on every state entry, saturates at its maximum.
// - Reset mid-operation: abort to IDLE within one cycle; a partially loaded image must be reloaded from word 0.
// TESTING
// - Load ramp img[k]=k&0x1FFF, busy model rises 3 cycles after ready:
//   - ready high exactly until busy is seen.
//   - idata for iaddr=4095 is 4095.
// - Write/read: cwr csel=0 addr=100 data=0x1ABC, then crd addr=100 -> cdata_rd=0x1ABC.
//   - Same address, csel=1 -> L1 contents, not 0x1ABC.
// - L1 writes k -> L1[k] for k=0..1023, drop busy:
//   - drain emits 0..1023 in order, out_last on 1023, done pulses once.
// - Drain backpressure: out_ready toggling 1010...
//   - no word duplicated or lost; out_data stable while stalled.
// - Busy never rises: err=1 after 16 HS cycles; FSM in IDLE; next load clears err.
// - Reset asserted at load word 2000:
//   - in_ready/ready/out_valid = 0 next cycle.
//   - fresh 4096-word load completes normally.

Source files
------------

// File: rtl/atconv_host.sv
// Host/memory side of the ATCONV accelerator: image loader, start handshake,
// layer-0/layer-1 scratch memories and the layer-1 result drain.
module atconv_host #(
  parameter int DW          = 13,
  parameter int AW          = 12,
  parameter int IMG_DEPTH   = 4096,
  parameter int L0_DEPTH    = 4096,
  parameter int L1_DEPTH    = 1024,
  parameter int HS_TIMEOUT  = 16,
  parameter int RUN_TIMEOUT = 1048575
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [DW-1:0]        in_data,
  output logic                 in_ready,
  output logic                 ready,
  input  logic                 busy,
  input  logic [AW-1:0]        iaddr,
  output logic signed [DW-1:0] idata,
  input  logic                 cwr,
  input  logic [AW-1:0]        caddr_wr,
  input  logic [DW-1:0]        cdata_wr,
  input  logic                 crd,
  input  logic [AW-1:0]        caddr_rd,
  output logic [DW-1:0]        cdata_rd,
  input  logic                 csel,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 done,
  output logic                 err
);

  localparam int L1_AW = $clog2(L1_DEPTH);
  localparam int TMO_W = $clog2(RUN_TIMEOUT + 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HS    = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]       state, state_nx;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    img_waddr;
  logic [L1_AW-1:0] rptr;
  logic [TMO_W-1:0] tmo;
  logic             in_fire, out_fire, last_word;
  logic             hs_expired, run_expired, timed_out;

  logic [DW-1:0] img_mem [IMG_DEPTH];
  logic [DW-1:0] l0_mem  [L0_DEPTH];
  logic [DW-1:0] l1_mem  [L1_DEPTH];

  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign last_word   = (rptr == L1_AW'(L1_DEPTH - 1));
  assign hs_expired  = (tmo == TMO_W'(HS_TIMEOUT));
  assign run_expired = (tmo > TMO_W'(RUN_TIMEOUT));
  assign timed_out   = ((state == S_HS) || (state == S_RUN)) && (state_nx == S_IDLE);
  assign img_waddr   = (state == S_IDLE) ? '0 : wptr;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_fire) state_nx = S_LOAD;
      S_LOAD:  if (in_fire && (wptr == AW'(IMG_DEPTH - 1))) state_nx = S_HS;
      S_HS: begin
        if (busy)            state_nx = S_RUN;
        else if (hs_expired) state_nx = S_IDLE;
      end
      S_RUN: begin
        if (!busy)            state_nx = S_DRAIN;
        else if (run_expired) state_nx = S_IDLE;
      end
      S_DRAIN: if (out_fire && last_word) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // in_ready/ready are registered from the next state so they read 0 in the reset cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      tmo      <= '0;
      in_ready <= 1'b0;
      ready    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx == S_IDLE) || (state_nx == S_LOAD);
      ready    <= (state_nx == S_HS);
      done     <= (state == S_DRAIN) && out_fire && last_word;

      if (state_nx != state)  tmo <= '0;
      else if (tmo != '1)     tmo <= tmo + 1'b1;

      if (in_fire) wptr <= img_waddr + 1'b1;

      if ((state == S_RUN) && (state_nx == S_DRAIN)) rptr <= '0;
      else if (out_fire)                             rptr <= rptr + 1'b1;

      if ((state == S_IDLE) && in_fire) err <= 1'b0;
      else if (timed_out)               err <= 1'b1;
    end
  end

  // Layer memories stay writable in every state so the host can poke them for debug
  always_ff @(posedge clk) begin
    if (reset && in_fire)  img_mem[img_waddr] <= in_data;
    if (cwr && !csel)      l0_mem[caddr_wr] <= cdata_wr;
    if (cwr && csel)       l1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
  end

  assign idata     = img_mem[iaddr];
  assign cdata_rd  = crd ? (csel ? l1_mem[caddr_rd[L1_AW-1:0]] : l0_mem[caddr_rd]) : '0;
  assign out_valid = (state == S_DRAIN);
  assign out_data  = l1_mem[rptr];
  assign out_last  = out_valid & last_word;

endmodule

// File: tb/tb_atconv_host.sv
// Randomized self-checking bench for atconv_host; shadow arrays model the three memories
// and the stream/handshake expectations are computed from the protocol rules.
module tb_atconv_host;

  localparam int DW = 13;
  localparam int AW = 12;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [DW-1:0]        in_data;
  logic                 in_ready;
  logic                 ready;
  logic                 busy;
  logic [AW-1:0]        iaddr;
  logic signed [DW-1:0] idata;
  logic                 cwr;
  logic [AW-1:0]        caddr_wr;
  logic [DW-1:0]        cdata_wr;
  logic                 crd;
  logic [AW-1:0]        caddr_rd;
  logic [DW-1:0]        cdata_rd;
  logic                 csel;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic                 out_last;
  logic                 out_ready;
  logic                 done;
  logic                 err;

  logic [DW-1:0] img_m [4096];
  logic [DW-1:0] l0_m  [4096];
  logic [DW-1:0] l1_m  [1024];

  int errors = 0;
  int checks = 0;

  atconv_host dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams words [first, last_excl) with random gaps; the shadow image records what was accepted
  task automatic load_words(input int first, input int last_excl, input bit ramp);
    int k;
    int cyc;
    k = first;
    cyc = 0;
    while (k < last_excl && cyc < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = ramp ? DW'(k) : DW'($urandom);
      if (in_valid && in_ready) begin
        img_m[k] = in_data;
        k++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (k != last_excl) begin
      errors++;
      $display("[TB] FAIL load_count accepted=%0d required=%0d", k, last_excl);
    end
  endtask

  task automatic write_layer(input bit sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cwr = 1'b1; csel = sel; caddr_wr = a; cdata_wr = d;
    tick();
    cwr = 1'b0;
    if (sel) l1_m[a[9:0]] = d;
    else     l0_m[a] = d;
  endtask

  // ready must be up right after the last word and stay up until busy is sampled
  task automatic handshake();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hs_ready_rise got=%b required=1", ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL hs_ready_hold cycle=%0d got=%b required=1", i, ready);
      end
    end
    busy = 1'b1;
    tick();
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hs_ready_drop got=%b required=0", ready);
    end
  endtask

  task automatic drain(input bit toggle);
    int idx;
    int cyc;
    int early_done;
    bit phase;
    bit stalled;
    logic [DW-1:0] held_data;
    logic held_last;
    idx = 0; cyc = 0; early_done = 0; phase = 1'b1; stalled = 1'b0;
    held_data = '0; held_last = 1'b0;
    busy = 1'b0;
    tick();
    while (idx < 1024 && cyc < 5000) begin
      out_ready = toggle ? phase : 1'b1;
      phase = ~phase;
      #1;
      if (done === 1'b1) early_done++;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
          errors++;
          $display("[TB] FAIL drain_hold idx=%0d got=%h/%b required=%h/%b", idx, out_data, out_last, held_data, held_last);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== l1_m[idx] || out_last !== (idx == 1023)) begin
          errors++;
          $display("[TB] FAIL drain_word idx=%0d got=%h/%b required=%h/%b", idx, out_data, out_last, l1_m[idx], (idx == 1023));
        end
      end
      stalled   = (out_valid === 1'b1) && !out_ready;
      held_data = out_data;
      held_last = out_last;
      if (out_valid === 1'b1 && out_ready) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (idx != 1024 || early_done != 0) begin
      errors++;
      $display("[TB] FAIL drain_count words=%0d required=1024 early_done=%0d", idx, early_done);
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_done got done=%b valid=%b required done=1 valid=0", done, out_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse got=%b required=0", done);
    end
  endtask

  task automatic test_image_read(input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n + 2; i++) begin
      if (i == 0)      a = 12'd4095;
      else if (i == 1) a = 12'd0;
      else             a = AW'($urandom);
      iaddr = a;
      #1;
      checks++;
      if (idata !== img_m[a]) begin
        errors++;
        $display("[TB] FAIL idata addr=%0d got=%h required=%h", a, idata, img_m[a]);
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({in_ready, ready, out_valid, out_last, done, err} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%b required=000000",
               {in_ready, ready, out_valid, out_last, done, err});
    end
    reset = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_in_ready got=%b required=1", in_ready);
    end
  endtask

  task automatic test_load_ramp();
    load_words(0, 4096, 1'b1);
    handshake();
    iaddr = 12'd4095;
    #1;
    checks++;
    if (idata !== 13'd4095) begin
      errors++;
      $display("[TB] FAIL ramp_4095 got=%0d required=4095", idata);
    end
    test_image_read(6);
  endtask

  task automatic test_mem_rw();
    logic sel;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    write_layer(1'b1, 12'd100, 13'h0055);
    write_layer(1'b0, 12'd100, 13'h1ABC);
    crd = 1'b1; csel = 1'b0; caddr_rd = 12'd100;
    #1;
    checks++;
    if (cdata_rd !== 13'h1ABC) begin
      errors++;
      $display("[TB] FAIL l0_read got=%h required=1abc", cdata_rd);
    end
    csel = 1'b1;
    #1;
    checks++;
    if (cdata_rd !== l1_m[100]) begin
      errors++;
      $display("[TB] FAIL l1_read got=%h required=%h", cdata_rd, l1_m[100]);
    end
    crd = 1'b0;
    #1;
    checks++;
    if (cdata_rd !== 13'h0) begin
      errors++;
      $display("[TB] FAIL read_idle got=%h required=0", cdata_rd);
    end
    // L1 ignores the upper address bits, so 0x8C8 aliases word 200
    write_layer(1'b1, 12'h8C8, 13'h0ABC);
    crd = 1'b1; csel = 1'b1; caddr_rd = 12'd200;
    #1;
    checks++;
    if (cdata_rd !== 13'h0ABC) begin
      errors++;
      $display("[TB] FAIL l1_alias got=%h required=0abc", cdata_rd);
    end
    crd = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sel = 1'($urandom);
      a   = AW'($urandom);
      d   = DW'($urandom);
      write_layer(sel, a, d);
      exp = sel ? l1_m[a[9:0]] : l0_m[a];
      crd = 1'b1; csel = sel; caddr_rd = a;
      #1;
      checks++;
      if (cdata_rd !== exp) begin
        errors++;
        $display("[TB] FAIL rand_rw sel=%0d addr=%0d got=%h required=%h", sel, a, cdata_rd, exp);
      end
      crd = 1'b0;
    end
    write_layer(1'b0, 12'd100, 13'h1ABC);
    cwr = 1'b1; csel = 1'b0; caddr_wr = 12'd100; cdata_wr = 13'h0777;
    crd = 1'b1; caddr_rd = 12'd100;
    #1;
    checks++;
    if (cdata_rd !== 13'h1ABC) begin
      errors++;
      $display("[TB] FAIL rdw_old got=%h required=1abc", cdata_rd);
    end
    tick();
    cwr = 1'b0;
    l0_m[100] = 13'h0777;
    #1;
    checks++;
    if (cdata_rd !== 13'h0777) begin
      errors++;
      $display("[TB] FAIL rdw_new got=%h required=0777", cdata_rd);
    end
    crd = 1'b0;
  endtask

  task automatic test_drain_ramp();
    for (int k = 0; k < 1024; k++) write_layer(1'b1, AW'(k), DW'(k));
    drain(1'b0);
  endtask

  task automatic test_back_to_back();
    load_words(0, 4096, 1'b0);
    handshake();
    test_image_read(8);
    for (int k = 0; k < 1024; k++) write_layer(1'b1, AW'(k), DW'($urandom));
    drain(1'b1);
  endtask

  task automatic test_hs_timeout();
    int cnt;
    load_words(0, 4096, 1'b0);
    cnt = 0;
    while (ready === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    // tmo starts at 0 on entry, so ready spans HS_TIMEOUT+1 cycles before the timeout edge
    checks++;
    if (cnt != 17) begin
      errors++;
      $display("[TB] FAIL hs_ready_cycles got=%0d required=17", cnt);
    end
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hs_timeout got err=%b in_ready=%b required err=1 in_ready=1", err, in_ready);
    end
    load_words(0, 1, 1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear got=%b required=0", err);
    end
  endtask

  task automatic test_reset_midload();
    load_words(1, 2000, 1'b0);
    reset = 1'b0;
    tick();
    checks++;
    if ({in_ready, ready, out_valid} !== 3'b0) begin
      errors++;
      $display("[TB] FAIL midload_reset got=%b required=000", {in_ready, ready, out_valid});
    end
    tick();
    reset = 1'b1;
    tick();
    load_words(0, 4096, 1'b0);
    handshake();
    test_image_read(6);
    drain(1'b0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; busy = 1'b0; iaddr = '0;
    cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0; caddr_rd = '0;
    csel = 1'b0; out_ready = 1'b0;
    $display("[TB] start");
    test_reset();
    test_load_ramp();
    test_mem_rw();
    test_drain_ramp();
    test_back_to_back();
    test_hs_timeout();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
